edge_detector: RTL and testbench



---
 rtl/edge_detector.sv | 73 +++++++
 tb/tb_edge_detector.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/edge_detector.sv
// edge_detector: per-lane edge-to-pulse converter
// optional input synchronizer and registered output
module edge_detector #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 0,
  parameter int EDGE_MODE      = 0,
  parameter int REGISTERED_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Detector
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] hit;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = D;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // shift D through the synchronizer chain
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          sync_q[0] <= D;
          for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // one-cycle history of the synchronized input
  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= s;
  end

  // select which transition counts as an edge
  always_comb begin
    hit = s & ~prev;
    case (EDGE_MODE)
      1:       hit = ~s & prev;
      2:       hit = s ^ prev;
      default: hit = s & ~prev;
    endcase
  end

  generate
    if (REGISTERED_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] det_q;

      // glitch-free pulse, one clock after the edge
      always_ff @(posedge clk) begin
        if (rst) det_q <= '0;
        else     det_q <= hit;
      end

      assign Detector = rst ? '0 : det_q;
    end else begin : g_comb
      assign Detector = rst ? '0 : hit;
    end
  endgenerate

endmodule

// File: tb/tb_edge_detector.sv
// tb_edge_detector: four configurations vs a
// cycle-history reference model
module tb_edge_detector;

  localparam int MAXC = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       da, db;
  logic [3:0] dc, dd;
  logic       qa, qb;
  logic [3:0] qc, qd;

  logic [3:0] xh [4][MAXC];
  logic       rh [MAXC];
  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int pa     = 0;
  int pb     = 0;

  always #5 clk = ~clk;

  edge_detector u_a (
    .clk(clk), .rst(rst), .D(da), .Detector(qa));

  edge_detector #(
    .EDGE_MODE(2), .REGISTERED_OUT(1)
  ) u_b (
    .clk(clk), .rst(rst), .D(db), .Detector(qb));

  edge_detector #(
    .WIDTH(4), .SYNC_STAGES(2), .REGISTERED_OUT(1)
  ) u_c (
    .clk(clk), .rst(rst), .D(dc), .Detector(qc));

  edge_detector #(
    .WIDTH(4), .SYNC_STAGES(1), .EDGE_MODE(1)
  ) u_d (
    .clk(clk), .rst(rst), .D(dd), .Detector(qd));

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  // s in interval k: input from n clocks ago, unless a
  // reset hit any of the n posedges in between
  function automatic logic [3:0] s_at(int i, int k, int n);
    if (k - n < 0) return 4'h0;
    for (int j = 1; j <= n; j++)
      if (rh[k-j]) return 4'h0;
    return xh[i][k-n];
  endfunction

  function automatic logic [3:0] hit_at(int i, int k,
                                        int n, int mode);
    logic [3:0] s, p;
    s = s_at(i, k, n);
    p = (k < 1 || rh[k-1]) ? 4'h0 : s_at(i, k-1, n);
    case (mode)
      0:       return s & ~p;
      1:       return ~s & p;
      default: return s ^ p;
    endcase
  endfunction

  function automatic logic [3:0] exp_at(int i, int k, int n,
                                        int mode, bit regd);
    if (rh[k]) return 4'h0;
    if (!regd) return hit_at(i, k, n, mode);
    if (k < 1 || rh[k-1]) return 4'h0;
    return hit_at(i, k-1, n, mode);
  endfunction

  task automatic step(input logic a, input logic b,
                      input logic [3:0] c, input logic [3:0] d,
                      input logic r, input bit glitch);
    @(posedge clk);
    #3;
    rst = r;
    da = a; db = b; dc = c; dd = d;
    xh[0][cyc] = {3'b000, a};
    xh[1][cyc] = {3'b000, b};
    xh[2][cyc] = c;
    xh[3][cyc] = d;
    rh[cyc] = r;
    if (glitch) begin
      #1; db = ~b; dc = ~c;
      #2; db = b;  dc = c;
      #2;
    end else begin
      #5;
    end
    check("a_rise", {3'b000, qa},
          exp_at(0, cyc, 0, 0, 1'b0) & 4'h1);
    check("b_both_reg", {3'b000, qb},
          exp_at(1, cyc, 0, 2, 1'b1) & 4'h1);
    check("c_sync2_reg", qc, exp_at(2, cyc, 2, 0, 1'b1));
    check("d_fall_sync1", qd, exp_at(3, cyc, 1, 1, 1'b0));
    if (qa === 1'b1) pa++;
    if (qb === 1'b1) pb++;
    cyc++;
  endtask

  initial begin
    logic       a, b, r;
    logic [3:0] c, d;
    rst = 1'b1;
    da = 1'b0; db = 1'b0; dc = 4'h0; dd = 4'h0;

    for (int k = 0; k < 14; k++) begin
      a = (k >= 4 && k < 7) || (k >= 10 && k < 13);
      b = (k >= 2 && k < 5);
      c = (k < 2) ? 4'h0 : (k < 10 ? 4'b0101 : 4'b1111);
      d = (k < 2) ? 4'h0 : (k < 8 ? 4'hF : 4'h3);
      r = (k < 2) || (k == 13);
      step(a, b, c, d, r, 1'b0);
      if (k == 5)  check("c_delay3", qc, 4'b0101);
      if (k == 13) check("c_rst_mid", qc, 4'h0);
    end
    check("a_pulse_cnt", pa[3:0], 4'd2);
    check("b_pulse_cnt", pb[3:0], 4'd2);

    a = 1'b0; b = 1'b0; c = 4'h0; d = 4'h0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 0) a = 1'($urandom);
      if ($urandom_range(0, 1) == 0) b = 1'($urandom);
      if ($urandom_range(0, 1) == 0) c = 4'($urandom);
      if ($urandom_range(0, 1) == 0) d = 4'($urandom);
      r = ($urandom_range(0, 24) == 0);
      step(a, b, c, d, r, $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
